// File: rtl/home_access_sequencer.sv
// Top-level smart-home access sequencer: gates commands behind authorization,
// enforces failed-attempt lockout, drives lighting/climate commands and the light timer tick.
//   state     | meaning
//   LOCKED    | waiting for key_press, commands ignored
//   AUTH_WAIT | auth requested, waiting for access_in or timeout
//   UNLOCKED  | user commands forwarded, idle auto-lock running
//   LOCKOUT   | too many failures, key_press ignored for a fixed time
//   EMERGENCY | safety override, lights forced on, everything else ignored
module home_access_sequencer #(
  parameter int AUTH_TIMEOUT   = 6,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 32,
  parameter int IDLE_TIMEOUT   = 64,
  parameter int LIGHT_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_press,
  input  logic       access_in,
  input  logic [1:0] safety_state,
  input  logic [1:0] light_state,
  input  logic       cmd_light,
  input  logic       cmd_dim,
  input  logic       cmd_climate,
  input  logic       cmd_lock,
  output logic       auth_start,
  output logic       light_switch_on,
  output logic       light_dim,
  output logic       light_timer_done,
  output logic       climate_enable,
  output logic [2:0] mode
);

  localparam int M1   = (AUTH_TIMEOUT > MAX_FAILS) ? AUTH_TIMEOUT : MAX_FAILS;
  localparam int M2   = (LOCKOUT_CYCLES > IDLE_TIMEOUT) ? LOCKOUT_CYCLES : IDLE_TIMEOUT;
  localparam int M3   = (M1 > M2) ? M1 : M2;
  localparam int MAXP = (M3 > LIGHT_TIMEOUT) ? M3 : LIGHT_TIMEOUT;
  localparam int CW   = $clog2(MAXP);

  localparam logic [CW-1:0] AUTH_LAST  = CW'(AUTH_TIMEOUT - 1);
  localparam logic [CW-1:0] FAIL_LAST  = CW'(MAX_FAILS - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_TIMEOUT - 1);
  localparam logic [CW-1:0] LIGHT_LAST = CW'(LIGHT_TIMEOUT - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  typedef enum logic [2:0] {
    LOCKED    = 3'd0,
    AUTH_WAIT = 3'd1,
    UNLOCKED  = 3'd2,
    LOCKOUT   = 3'd3,
    EMERGENCY = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0] fail_cnt_q, fail_cnt_d;
  logic [CW-1:0] lockout_cnt_q, lockout_cnt_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW-1:0] light_cnt_q, light_cnt_d;
  logic          auth_start_q, auth_start_d;
  logic          light_on_q, light_on_d;
  logic          light_dim_q, light_dim_d;
  logic          timer_done_q, timer_done_d;
  logic          climate_q, climate_d;
  logic          alarm;

  assign alarm = (safety_state == 2'b01);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= LOCKED;
      wait_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      lockout_cnt_q <= '0;
      idle_cnt_q    <= '0;
      light_cnt_q   <= '0;
      auth_start_q  <= 1'b0;
      light_on_q    <= 1'b0;
      light_dim_q   <= 1'b0;
      timer_done_q  <= 1'b0;
      climate_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      lockout_cnt_q <= lockout_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      light_cnt_q   <= light_cnt_d;
      auth_start_q  <= auth_start_d;
      light_on_q    <= light_on_d;
      light_dim_q   <= light_dim_d;
      timer_done_q  <= timer_done_d;
      climate_q     <= climate_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    lockout_cnt_d = lockout_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    light_cnt_d   = light_cnt_q;
    climate_d     = climate_q;
    auth_start_d  = 1'b0;
    light_on_d    = 1'b0;
    light_dim_d   = 1'b0;
    timer_done_d  = 1'b0;

    if (safety_state == 2'b10) begin
      state_d       = EMERGENCY;
      wait_cnt_d    = '0;
      fail_cnt_d    = '0;
      lockout_cnt_d = '0;
      idle_cnt_d    = '0;
      light_cnt_d   = '0;
      climate_d     = 1'b0;
      light_on_d    = 1'b1;
    end else begin
      case (state_q)
        LOCKED: begin
          if (key_press) begin
            state_d      = AUTH_WAIT;
            wait_cnt_d   = '0;
            auth_start_d = 1'b1;
          end
        end
        AUTH_WAIT: begin
          wait_cnt_d = wait_cnt_q + ONE;
          if (access_in) begin
            state_d    = UNLOCKED;
            fail_cnt_d = '0;
            idle_cnt_d = '0;
          end else if (wait_cnt_q == AUTH_LAST) begin
            if (fail_cnt_q == FAIL_LAST) begin
              state_d       = LOCKOUT;
              lockout_cnt_d = '0;
            end else begin
              state_d    = LOCKED;
              fail_cnt_d = fail_cnt_q + ONE;
            end
          end
        end
        LOCKOUT: begin
          lockout_cnt_d = lockout_cnt_q + ONE;
          if (lockout_cnt_q == LOCK_LAST) begin
            state_d    = LOCKED;
            fail_cnt_d = '0;
          end
        end
        UNLOCKED: begin
          // during ALARM commands are dropped and do not count as activity
          if (!alarm && cmd_lock) begin
            state_d    = LOCKED;
            idle_cnt_d = '0;
          end else if (!alarm && (cmd_light || cmd_dim || cmd_climate)) begin
            light_on_d  = cmd_light;
            light_dim_d = cmd_dim && !cmd_light;
            if (cmd_climate) climate_d = !climate_q;
            idle_cnt_d = '0;
          end else if (idle_cnt_q == IDLE_LAST) begin
            state_d    = LOCKED;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + ONE;
          end
        end
        EMERGENCY: state_d = LOCKED;
        default:   state_d = LOCKED;
      endcase

      if (state_q != EMERGENCY) begin
        if (light_state[0]) begin
          if (light_cnt_q == LIGHT_LAST) begin
            light_cnt_d  = '0;
            timer_done_d = 1'b1;
          end else begin
            light_cnt_d = light_cnt_q + ONE;
          end
        end else begin
          light_cnt_d = '0;
        end
      end
    end
  end

  assign auth_start       = auth_start_q;
  assign light_switch_on  = light_on_q;
  assign light_dim        = light_dim_q;
  assign light_timer_done = timer_done_q;
  assign climate_enable   = climate_q;
  assign mode             = state_q;

endmodule

// File: tb/tb_home_access_sequencer.sv
// Scoreboard bench for home_access_sequencer: stimulus pushes expected pulse cycles
// and level values; a negedge monitor pops and compares as the DUT presents them.
module tb_home_access_sequencer;

  localparam int P_AUTH = 0, P_LON = 1, P_DIM = 2, P_TMR = 3;
  localparam int L_MODE = 0, L_CLIM = 1, L_ALL = 2;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } lexp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_press;
  logic       access_in = 1'b0;
  logic [1:0] safety_state;
  logic [1:0] light_state;
  logic       cmd_light, cmd_dim, cmd_climate, cmd_lock;
  logic       auth_start, light_switch_on, light_dim, light_timer_done, climate_enable;
  logic [2:0] mode;
  logic       grant_en;

  int    cyc = 0;
  int    compared = 0;
  int    mismatched = 0;
  int    pq[4][$];
  lexp_t lq[$];

  home_access_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .key_press        (key_press),
    .access_in        (access_in),
    .safety_state     (safety_state),
    .light_state      (light_state),
    .cmd_light        (cmd_light),
    .cmd_dim          (cmd_dim),
    .cmd_climate      (cmd_climate),
    .cmd_lock         (cmd_lock),
    .auth_start       (auth_start),
    .light_switch_on  (light_switch_on),
    .light_dim        (light_dim),
    .light_timer_done (light_timer_done),
    .climate_enable   (climate_enable),
    .mode             (mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string pname(input int k);
    case (k)
      P_AUTH:  return "auth_start";
      P_LON:   return "light_switch_on";
      P_DIM:   return "light_dim";
      default: return "light_timer_done";
    endcase
  endfunction

  function automatic string lname(input int s);
    case (s)
      L_MODE:  return "mode";
      L_CLIM:  return "climate_enable";
      default: return "all_outputs";
    endcase
  endfunction

  // authorization FSM model: grants access three cycles after auth_start
  always begin
    @(negedge clk);
    if (grant_en && auth_start) begin
      repeat (3) @(posedge clk);
      #1 access_in = 1'b1;
      @(posedge clk);
      #1 access_in = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [3:0] p;
    int         e;
    int         act;
    p = {light_timer_done, light_dim, light_switch_on, auth_start};
    for (int k = 0; k < 4; k++) begin
      if (p[k]) begin
        compared++;
        if (pq[k].size() == 0) begin
          mismatched++;
          $display("FAIL %s: pulse seen at cycle %0d, required no pulse", pname(k), cyc);
        end else begin
          e = pq[k].pop_front();
          if (e != cyc) begin
            mismatched++;
            $display("FAIL %s: pulse seen at cycle %0d, required at cycle %0d", pname(k), cyc, e);
          end
        end
      end
    end
    for (int i = lq.size() - 1; i >= 0; i--) begin
      if (lq[i].cyc == cyc) begin
        case (lq[i].sig)
          L_MODE:  act = int'(mode);
          L_CLIM:  act = int'(climate_enable);
          default: act = int'({auth_start, light_switch_on, light_dim, light_timer_done,
                               climate_enable, mode});
        endcase
        compared++;
        if (act != lq[i].val) begin
          mismatched++;
          $display("FAIL %s @cycle %0d: got %0d, required %0d", lname(lq[i].sig), cyc, act,
                   lq[i].val);
        end
        lq.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void exp_pulse(input int k, input int c);
    pq[k].push_back(c);
  endfunction

  function automatic void exp_lvl(input int c, input int s, input int v);
    lexp_t x;
    x.cyc = c;
    x.sig = s;
    x.val = v;
    lq.push_back(x);
  endfunction

  task automatic cmd(input logic l, input logic d, input logic c, input logic k);
    cmd_light = l; cmd_dim = d; cmd_climate = c; cmd_lock = k;
    step();
    cmd_light = 0; cmd_dim = 0; cmd_climate = 0; cmd_lock = 0;
  endtask

  task automatic attempt(output int a);
    exp_pulse(P_AUTH, cyc + 1);
    exp_lvl(cyc + 1, L_MODE, 1);
    key_press = 1'b1;
    step();
    key_press = 1'b0;
    a = cyc;
  endtask

  task automatic unlock(output int u);
    int a;
    grant_en = 1'b1;
    attempt(a);
    exp_lvl(a + 3, L_MODE, 1);
    exp_lvl(a + 4, L_MODE, 2);
    repeat (4) step();
    grant_en = 1'b0;
    u = cyc;
  endtask

  task automatic fail_attempt(input bit to_lockout);
    int a;
    attempt(a);
    exp_lvl(a + 5, L_MODE, 1);
    exp_lvl(a + 6, L_MODE, to_lockout ? 3 : 0);
    repeat (6) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int u, a, lk, s, r;
    reset = 1'b1; key_press = 0; safety_state = 2'b00; light_state = 2'b00;
    cmd_light = 0; cmd_dim = 0; cmd_climate = 0; cmd_lock = 0; grant_en = 0;
    repeat (3) step();
    exp_lvl(cyc, L_ALL, 0);
    reset = 1'b0;
    exp_lvl(cyc + 1, L_MODE, 0);
    step();
    step();

    // unlock and forward commands
    unlock(u);
    exp_pulse(P_LON, cyc + 1); cmd(1, 0, 0, 0);
    exp_pulse(P_DIM, cyc + 1); cmd(0, 1, 0, 0);
    exp_pulse(P_LON, cyc + 1); cmd(1, 1, 0, 0);
    exp_lvl(cyc + 1, L_CLIM, 1); cmd(0, 0, 1, 0);
    exp_lvl(cyc + 1, L_CLIM, 0); cmd(0, 0, 1, 0);
    exp_lvl(cyc + 1, L_CLIM, 1); cmd(0, 0, 1, 0);
    exp_lvl(cyc + 1, L_MODE, 0); cmd(1, 1, 0, 1);
    cmd(1, 1, 1, 0);
    exp_lvl(cyc + 2, L_CLIM, 1);
    step(); step();

    // three failures -> lockout, keys ignored, then fail count cleared
    fail_attempt(0);
    fail_attempt(0);
    fail_attempt(1);
    lk = cyc;
    exp_lvl(lk + 10, L_CLIM, 1);
    exp_lvl(lk + 31, L_MODE, 3);
    exp_lvl(lk + 32, L_MODE, 0);
    for (int i = 1; i <= 31; i++) begin
      key_press = (i % 4 == 1);
      step();
    end
    key_press = 1'b0;
    step();
    fail_attempt(0);
    fail_attempt(0);
    exp_lvl(cyc + 1, L_MODE, 0);
    step();

    // idle auto-lock
    unlock(u);
    exp_lvl(u + 63, L_MODE, 2);
    exp_lvl(u + 64, L_MODE, 0);
    exp_lvl(u + 65, L_CLIM, 1);
    repeat (65) step();
    unlock(u);
    repeat (19) step();
    exp_lvl(u + 20, L_CLIM, 0); cmd(0, 0, 1, 0);
    repeat (19) step();
    exp_lvl(u + 40, L_CLIM, 1); cmd(0, 0, 1, 0);
    exp_lvl(u + 103, L_MODE, 2);
    exp_lvl(u + 104, L_MODE, 0);
    exp_lvl(u + 105, L_CLIM, 1);
    repeat (65) step();

    // light timer
    s = cyc;
    light_state = 2'b01;
    exp_pulse(P_TMR, s + 16); exp_pulse(P_TMR, s + 32); exp_pulse(P_TMR, s + 48);
    repeat (50) step();
    light_state = 2'b10;
    repeat (20) step();
    r = cyc;
    light_state = 2'b01;
    exp_pulse(P_TMR, r + 16);
    repeat (16) step();
    light_state = 2'b00;
    repeat (3) step();

    // emergency during AUTH_WAIT
    attempt(a);
    step();
    safety_state = 2'b10;
    exp_lvl(a + 2, L_MODE, 4);
    exp_lvl(a + 2, L_CLIM, 0);
    exp_pulse(P_LON, a + 2); exp_pulse(P_LON, a + 3); exp_pulse(P_LON, a + 4);
    key_press = 1; cmd_light = 1; cmd_climate = 1;
    step(); step();
    key_press = 0; cmd_light = 0; cmd_climate = 0;
    step();
    safety_state = 2'b00;
    exp_lvl(a + 5, L_MODE, 0);
    exp_lvl(a + 8, L_MODE, 0);
    exp_lvl(a + 8, L_CLIM, 0);
    repeat (4) step();

    // ALARM in UNLOCKED: commands dropped, idle lock still fires
    unlock(u);
    safety_state = 2'b01;
    cmd_light = 1;
    exp_lvl(u + 63, L_MODE, 2);
    exp_lvl(u + 64, L_MODE, 0);
    repeat (64) step();
    cmd_light = 0;
    safety_state = 2'b00;
    step();

    // reset mid-lockout loses the fail count
    fail_attempt(0);
    fail_attempt(0);
    fail_attempt(1);
    lk = cyc;
    exp_lvl(lk + 3, L_MODE, 3);
    repeat (4) step();
    reset = 1'b1;
    exp_lvl(cyc, L_ALL, 0);
    step(); step();
    reset = 1'b0;
    exp_lvl(cyc + 1, L_MODE, 0);
    step();
    fail_attempt(0);
    exp_lvl(cyc + 1, L_MODE, 0);
    repeat (3) step();

    for (int k = 0; k < 4; k++) begin
      while (pq[k].size() > 0) begin
        compared++;
        mismatched++;
        $display("FAIL %s: no pulse seen, required at cycle %0d", pname(k), pq[k].pop_front());
      end
    end
    while (lq.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: never sampled, required %0d at cycle %0d", lname(lq[0].sig), lq[0].val,
               lq[0].cyc);
      void'(lq.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
